// File: rtl/cpu_ifetch_q.sv
// -----------------------------------------------------------------------------
// cpu_ifetch_q
//   Instruction-fetch stage with a prefetch FIFO. Issues sequential word reads
//   to a synchronous instruction SRAM (1-cycle read latency), buffers up to
//   FIFO_DEPTH {pc, instr} pairs and hands them to decode over a valid/ready
//   handshake. An execute redirect flushes the FIFO, drops the in-flight read
//   and restarts fetch at the jump target in the same cycle.
//
// Parameters
//   ADDR_W      SRAM word-address width (m_addr = pc[ADDR_W+1:2])
//   FIFO_DEPTH  prefetch entries, power of two, >= 2
//   RESET_PC    first fetch address after reset
//
// Ports
//   clk        in   clock, all state on posedge
//   rst        in   synchronous active-high reset
//   e_j_flag   in   redirect request from execute
//   e_pc_next  in   redirect target, bits [1:0] ignored
//   m_ren      out  SRAM read enable (combinational)
//   m_addr     out  SRAM word address (combinational)
//   m_rdata    in   SRAM read data, valid the cycle after m_ren
//   f_valid    out  instruction available to decode
//   f_ready    in   decode accepts the instruction
//   f_instr    out  instruction word
//   f_pc       out  byte address of f_instr
//
// Configuration
//   IFETCH_BYPASS_EN  when defined, a response arriving into an empty FIFO is
//                     presented to decode in the same cycle (latency 1). When
//                     not defined, decode always sees the FIFO head (latency 2).
// -----------------------------------------------------------------------------
module cpu_ifetch_q #(
    parameter int          ADDR_W     = 10,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              e_j_flag,
    input  logic [31:0]       e_pc_next,
    output logic              m_ren,
    output logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_rdata,
    output logic              f_valid,
    input  logic              f_ready,
    output logic [31:0]       f_instr,
    output logic [31:0]       f_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    // Architectural state
    logic [31:0]      pc_r;
    logic             rsp_v_r;
    logic [31:0]      rsp_pc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [31:0]      mem_pc_r    [FIFO_DEPTH];
    logic [31:0]      mem_instr_r [FIFO_DEPTH];

    // Combinational control
    logic [31:0] tgt_s;
    logic        empty_s;
    logic        byp_s;
    logic        f_valid_s;
    logic        pop_s;
    logic        fifo_pop_s;
    logic        push_s;
    logic [CNT_W:0] occ_s;
    logic        issue_s;
    logic        unused_s;

    // Low target bits are architecturally ignored.
    assign unused_s = ^e_pc_next[1:0];
    assign tgt_s    = {e_pc_next[31:2], 2'b00};
    assign empty_s  = (cnt_r == {CNT_W{1'b0}});

    // Handshake, push/pop and issue decisions for the current cycle
    always_comb begin
        byp_s = 1'b0;
`ifdef IFETCH_BYPASS_EN
        byp_s = empty_s && rsp_v_r && !e_j_flag && !rst;
`endif
        f_valid_s  = !rst && !e_j_flag && (!empty_s || byp_s);
        pop_s      = f_valid_s && f_ready;
        fifo_pop_s = pop_s && !empty_s;
        // A bypassed response consumed directly by decode never enters the FIFO.
        push_s     = rsp_v_r && !e_j_flag && !rst && !(byp_s && f_ready);
        // Occupancy once this cycle's response lands and the pop leaves; the
        // next read may only issue if its response is guaranteed a slot.
        occ_s      = {1'b0, cnt_r} + {{CNT_W{1'b0}}, rsp_v_r} - {{CNT_W{1'b0}}, pop_s};
        if (rst) begin
            issue_s = 1'b0;
        end else if (e_j_flag) begin
            issue_s = 1'b1;
        end else begin
            issue_s = (occ_s < DEPTH_C);
        end
    end

    assign m_ren   = issue_s;
    assign m_addr  = e_j_flag ? tgt_s[ADDR_W+1:2] : pc_r[ADDR_W+1:2];
    assign f_valid = f_valid_s;

    // Output data: FIFO head, bypassed response, or zero when nothing is held
    always_comb begin
        if (!empty_s) begin
            f_pc    = mem_pc_r[rd_ptr_r];
            f_instr = mem_instr_r[rd_ptr_r];
        end else if (byp_s) begin
            f_pc    = rsp_pc_r;
            f_instr = m_rdata;
        end else begin
            f_pc    = 32'h0000_0000;
            f_instr = 32'h0000_0000;
        end
    end

    // Fetch pointer, in-flight read tracking and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            rsp_v_r  <= 1'b0;
            rsp_pc_r <= 32'h0000_0000;
            cnt_r    <= {CNT_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else if (e_j_flag) begin
            // The target read issues this cycle, so it is the in-flight read next.
            pc_r     <= tgt_s + 32'd4;
            rsp_v_r  <= 1'b1;
            rsp_pc_r <= tgt_s;
            cnt_r    <= {CNT_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (issue_s) begin
                pc_r     <= pc_r + 32'd4;
                rsp_v_r  <= 1'b1;
                rsp_pc_r <= pc_r;
            end else begin
                rsp_v_r  <= 1'b0;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, fifo_pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // FIFO storage; contents are only observed through the count, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_r[wr_ptr_r]    <= rsp_pc_r;
            mem_instr_r[wr_ptr_r] <= m_rdata;
        end
    end

endmodule

// File: tb/tb_cpu_ifetch_q.sv
module tb_cpu_ifetch_q;

    localparam int          ADDR_W = 10;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef IFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic              clk;
    logic              rst;
    logic              e_j_flag;
    logic [31:0]       e_pc_next;
    logic              m_ren;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_rdata;
    logic              f_valid;
    logic              f_ready;
    logic [31:0]       f_instr;
    logic [31:0]       f_pc;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    logic [31:0] exp_q[$];

    cpu_ifetch_q #(
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(4),
        .RESET_PC  (RST_PC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .e_j_flag (e_j_flag),
        .e_pc_next(e_pc_next),
        .m_ren    (m_ren),
        .m_addr   (m_addr),
        .m_rdata  (m_rdata),
        .f_valid  (f_valid),
        .f_ready  (f_ready),
        .f_instr  (f_instr),
        .f_pc     (f_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: word k holds 0xA000_0000 + k, one-cycle read latency
    always @(posedge clk) begin
        if (m_ren) m_rdata <= 32'hA000_0000 + 32'(m_addr);
    end

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return 32'hA000_0000 + {22'd0, pc[ADDR_W+1:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected delivery stream after a reset or redirect
    task automatic push_stream(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        int n;
        n = 0;
        look();
        while (!f_valid && n < maxc) begin
            nxt();
            look();
            n++;
        end
        chk(tag, 32'(f_valid), 32'd1);
    endtask

    // Scoreboard: every accepted transfer must match the next expected pc/instr
    always @(negedge clk) begin
        if (f_valid && f_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", f_pc, e);
                chk("sb_instr", f_instr, exp_instr(e));
            end
        end
    end

    initial begin
        int n_iss;
        int p0;
        rst       = 1'b1;
        e_j_flag  = 1'b0;
        e_pc_next = 32'h0000_0000;
        f_ready   = 1'b1;

        // Reset state
        nxt(); nxt(); look();
        chk("rst_valid", 32'(f_valid), 32'd0);
        chk("rst_ren",   32'(m_ren),   32'd0);
        chk("rst_pc",    f_pc,         32'd0);
        chk("rst_instr", f_instr,      32'd0);

        // T1: streaming from RESET_PC with decode always ready
        nxt(); rst = 1'b0; push_stream(RST_PC, 64);
        look();
        chk("t1_ren",  32'(m_ren),  32'd1);
        chk("t1_addr", 32'(m_addr), 32'h40);
        for (int c = 0; c < 7; c++) begin
            if (c != 0) begin nxt(); look(); end
            chk("t1_valid", 32'(f_valid), (c >= LAT) ? 32'd1 : 32'd0);
            if (c == LAT) chk("t1_first_pc", f_pc, RST_PC);
        end

        // T2: back-pressure fills the FIFO, then drains without loss
        nxt(); rst = 1'b1; f_ready = 1'b0; push_stream(RST_PC, 64);
        nxt(); rst = 1'b0;
        look();
        n_iss = 0;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) begin nxt(); look(); end
            if (m_ren) n_iss++;
        end
        chk("t2_issues", 32'(n_iss),   32'd4);
        chk("t2_ren",    32'(m_ren),   32'd0);
        chk("t2_valid",  32'(f_valid), 32'd1);
        chk("t2_head",   f_pc,         RST_PC);
        chk("t2_instr",  f_instr,      32'hA000_0040);
        nxt(); f_ready = 1'b1; p0 = n_pop;
        repeat (8) nxt();
        chk("t2_drained", 32'(n_pop - p0), 32'd8);

        // T3: redirect with 3 entries buffered and a read in flight
        nxt(); rst = 1'b1; f_ready = 1'b0; push_stream(RST_PC, 64);
        nxt(); rst = 1'b0;
        repeat (4) nxt();
        e_j_flag = 1'b1; e_pc_next = 32'h0000_0200; f_ready = 1'b1;
        push_stream(32'h0000_0200, 64);
        look();
        chk("t3_ren",   32'(m_ren),   32'd1);
        chk("t3_addr",  32'(m_addr),  32'h80);
        chk("t3_valid", 32'(f_valid), 32'd0);
        nxt(); e_j_flag = 1'b0;
        wait_valid("t3_wait", 8);
        chk("t3_pc", f_pc, 32'h0000_0200);

        // T4: back-to-back redirects, the last one wins
        nxt(); nxt();
        e_j_flag = 1'b1; e_pc_next = 32'h0000_0300; exp_q.delete();
        look();
        chk("t4_addr0",  32'(m_addr),  32'hC0);
        chk("t4_valid0", 32'(f_valid), 32'd0);
        nxt(); e_pc_next = 32'h0000_0400; push_stream(32'h0000_0400, 64);
        look();
        chk("t4_addr1",  32'(m_addr),  32'h100);
        chk("t4_valid1", 32'(f_valid), 32'd0);
        nxt(); e_j_flag = 1'b0;
        wait_valid("t4_wait", 8);
        chk("t4_pc", f_pc, 32'h0000_0400);

        // T5: pc and SRAM address wrap
        nxt(); nxt();
        e_j_flag = 1'b1; e_pc_next = 32'hFFFF_FFF8; push_stream(32'hFFFF_FFF8, 64);
        p0 = n_pop;
        look();
        chk("t5_addr0", 32'(m_addr), 32'h3FE);
        nxt(); e_j_flag = 1'b0;
        look();
        chk("t5_ren1",  32'(m_ren),  32'd1);
        chk("t5_addr1", 32'(m_addr), 32'h3FF);
        nxt(); look();
        chk("t5_addr2", 32'(m_addr), 32'h000);
        repeat (4) nxt();
        chk("t5_delivered", 32'((n_pop - p0) >= 3), 32'd1);

        // T6: reset with the FIFO full
        f_ready = 1'b0;
        repeat (8) nxt();
        look();
        chk("t6_full_valid", 32'(f_valid), 32'd1);
        chk("t6_full_ren",   32'(m_ren),   32'd0);
        nxt(); rst = 1'b1; push_stream(RST_PC, 64);
        look();
        chk("t6_rst_valid", 32'(f_valid), 32'd0);
        chk("t6_rst_ren",   32'(m_ren),   32'd0);
        nxt(); rst = 1'b0; f_ready = 1'b1;
        look();
        chk("t6_post_valid", 32'(f_valid), 32'd0);
        chk("t6_post_pc",    f_pc,         32'd0);
        nxt();
        wait_valid("t6_wait", 8);
        chk("t6_pc", f_pc, RST_PC);
        repeat (3) nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
